layer_mixer: RTL and testbench

LAYER_MIXER -- requirements
Module: layer_mixer

---
 rtl/mixer_pkg.sv | 27 ++
 rtl/mixer_stage.sv | 102 ++++++++++
 rtl/layer_mixer.sv | 158 +++++++++++++++
 tb/tb_layer_mixer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// mixer_pkg: shared types and constants for the layer mixer.
//   blend_mode_t : per-layer blend mode encoding
//   pixel_t      : {r,g,b} pixel at the default channel width
//   DEF_CW       : default bits per colour channel
//   mode_enabled : true for the modes that draw something (over, add)
package mixer_pkg;

    localparam int DEF_CW = 4;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_OVER = 2'b01,
        MODE_ADD  = 2'b10,
        MODE_RSVD = 2'b11
    } blend_mode_t;

    typedef struct packed {
        logic [DEF_CW-1:0] r;
        logic [DEF_CW-1:0] g;
        logic [DEF_CW-1:0] b;
    } pixel_t;

    function automatic logic mode_enabled(input logic [1:0] mode);
        return (mode == MODE_OVER) || (mode == MODE_ADD);
    endfunction

endpackage

// File: rtl/mixer_stage.sv
// mixer_stage: one layer-apply pipeline stage.
//   clk, rst_n, ce                 : clock, async active-low reset, pixel enable
//   valid_d, hsync_d, vsync_d      : timing from the previous stage
//   acc_d, cnt_d                   : accumulated {R,G,B} and opaque-hit count
//   lay_d, alpha_d, mode           : this stage's layer colour, alpha, blend mode
//   valid_q, hsync_q, vsync_q      : registered timing
//   acc_q, cnt_q                   : registered blend result and hit count
module mixer_stage
    import mixer_pkg::*;
#(
    parameter int   CW        = DEF_CW,
    parameter int   LAYER_IDX = 0,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          valid_d,
    input  logic          hsync_d,
    input  logic          vsync_d,
    input  logic [3*CW-1:0] acc_d,
    input  logic [1:0]    cnt_d,
    input  logic [3*CW-1:0] lay_d,
    input  logic          alpha_d,
    input  logic [1:0]    mode,
    output logic          valid_q,
    output logic          hsync_q,
    output logic          vsync_q,
    output logic [3*CW-1:0] acc_q,
    output logic [1:0]    cnt_q
);

    // Layer 0 is the base layer and never contributes to collisions.
    localparam logic COUNTS_HITS = (LAYER_IDX != 32'sd0);

    logic [3*CW-1:0] blend_s;
    logic            hit_s;
    logic [1:0]      cnt_nxt_s;

    // Per-channel add clamped at full scale via a one-bit-wider sum.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum[CW]) begin
            return {CW{1'b1}};
        end else begin
            return sum[CW-1:0];
        end
    endfunction

    // Blend this layer onto the accumulator.
    always_comb begin
        blend_s = acc_d;
        case (blend_mode_t'(mode))
            MODE_OVER: begin
                if (alpha_d) begin
                    blend_s = lay_d;
                end else begin
                    blend_s = acc_d;
                end
            end
            MODE_ADD: begin
                if (alpha_d) begin
                    for (int c = 0; c < 3; c++) begin
                        blend_s[c*CW +: CW] = sat_add(acc_d[c*CW +: CW], lay_d[c*CW +: CW]);
                    end
                end else begin
                    blend_s = acc_d;
                end
            end
            default: blend_s = acc_d;
        endcase
    end

    // Opaque-hit counter, saturating at 3.
    always_comb begin
        hit_s = COUNTS_HITS && alpha_d && mode_enabled(mode);
        if (hit_s && (cnt_d != 2'b11)) begin
            cnt_nxt_s = cnt_d + 2'b01;
        end else begin
            cnt_nxt_s = cnt_d;
        end
    end

    // Stage register; blanked colour when the pixel is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            acc_q   <= {(3*CW){1'b0}};
            cnt_q   <= 2'b00;
        end else if (ce) begin
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            acc_q   <= valid_d ? blend_s : {(3*CW){1'b0}};
            cnt_q   <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// layer_mixer: composites NUM_LAYERS 1-bit-alpha layers over a background.
//   clk, rst_n, pix_ce              : clock, async active-low reset, pixel enable
//   valid_i, hsync_i, vsync_i       : raw timing in
//   r_i, g_i, b_i, a_i, mode_i      : per-layer colour, alpha and blend mode
//   bg_i                            : background {R,G,B}
//   r_o, g_o, b_o                   : composited pixel (0 when not valid)
//   valid_o, hsync_o, vsync_o       : timing aligned to the pixel
//   collision_o                     : collision seen during the previous frame
//   frame_o                         : one-clk pulse at the output frame boundary
// Latency is NUM_LAYERS+1 enabled cycles: one input stage plus one per layer.
// Both syncs share the polarity selected by VS_ACTIVE_LOW.
module layer_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_LAYERS    = 4,
    parameter int CW            = DEF_CW,
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_ce,
    input  logic                     valid_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic [NUM_LAYERS*CW-1:0] r_i,
    input  logic [NUM_LAYERS*CW-1:0] g_i,
    input  logic [NUM_LAYERS*CW-1:0] b_i,
    input  logic [NUM_LAYERS-1:0]    a_i,
    input  logic [2*NUM_LAYERS-1:0]  mode_i,
    input  logic [3*CW-1:0]          bg_i,
    output logic [CW-1:0]            r_o,
    output logic [CW-1:0]            g_o,
    output logic [CW-1:0]            b_o,
    output logic                     valid_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     collision_o,
    output logic                     frame_o
);

    localparam logic SYNC_IDLE = (VS_ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;
    localparam int   LW        = 3*CW + 1;   // {alpha, R, G, B}

    // Stage chain: index 0 is the input register, index k the output of stage k.
    logic            v_s   [0:NUM_LAYERS];
    logic            hs_s  [0:NUM_LAYERS];
    logic            vs_s  [0:NUM_LAYERS];
    logic [3*CW-1:0] acc_s [0:NUM_LAYERS];
    logic [1:0]      cnt_s [0:NUM_LAYERS];

    logic            valid0_r, hs0_r, vs0_r;
    logic [3*CW-1:0] acc0_r;
    logic [2*NUM_LAYERS-1:0] mode_sh_r;
    logic            vs_start_in_s, vs_start_out_s, hit_out_s;
    logic            frame_r, collision_r, coll_acc_r;

    assign vs_start_in_s  = (vsync_i != SYNC_IDLE) && (vs0_r == SYNC_IDLE);
    assign vs_start_out_s = (vs_s[NUM_LAYERS-1] != SYNC_IDLE) && (vs_s[NUM_LAYERS] == SYNC_IDLE);
    assign hit_out_s      = v_s[NUM_LAYERS] && cnt_s[NUM_LAYERS][1];

    // Input stage; the mode shadow only moves at the input-side vsync start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_r  <= 1'b0;
            hs0_r     <= SYNC_IDLE;
            vs0_r     <= SYNC_IDLE;
            acc0_r    <= {(3*CW){1'b0}};
            mode_sh_r <= {(2*NUM_LAYERS){1'b0}};
        end else if (pix_ce) begin
            valid0_r <= valid_i;
            hs0_r    <= hsync_i;
            vs0_r    <= vsync_i;
            acc0_r   <= bg_i;
            if (vs_start_in_s) begin
                mode_sh_r <= mode_i;
            end
        end
    end

    assign v_s[0]   = valid0_r;
    assign hs_s[0]  = hs0_r;
    assign vs_s[0]  = vs0_r;
    assign acc_s[0] = acc0_r;
    assign cnt_s[0] = 2'b00;

    for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_layer
        // Layer j rides a delay line of j+1 registers so it meets its pixel at stage j+1.
        logic [LW-1:0] dly_r [0:j];

        // Delay line for this layer's colour and alpha.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= j; i++) begin
                    dly_r[i] <= {LW{1'b0}};
                end
            end else if (pix_ce) begin
                dly_r[0] <= {a_i[j], r_i[j*CW +: CW], g_i[j*CW +: CW], b_i[j*CW +: CW]};
                for (int i = 1; i <= j; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
        end

        mixer_stage #(
            .CW        (CW),
            .LAYER_IDX (j),
            .SYNC_IDLE (SYNC_IDLE)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .ce      (pix_ce),
            .valid_d (v_s[j]),
            .hsync_d (hs_s[j]),
            .vsync_d (vs_s[j]),
            .acc_d   (acc_s[j]),
            .cnt_d   (cnt_s[j]),
            .lay_d   (dly_r[j][3*CW-1:0]),
            .alpha_d (dly_r[j][3*CW]),
            .mode    (mode_sh_r[2*j +: 2]),
            .valid_q (v_s[j+1]),
            .hsync_q (hs_s[j+1]),
            .vsync_q (vs_s[j+1]),
            .acc_q   (acc_s[j+1]),
            .cnt_q   (cnt_s[j+1])
        );
    end

    // Frame pulse and collision bookkeeping; a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r     <= 1'b0;
            collision_r <= 1'b0;
            coll_acc_r  <= 1'b0;
        end else begin
            frame_r <= pix_ce && vs_start_out_s;
            if (pix_ce) begin
                if (vs_start_out_s) begin
                    collision_r <= coll_acc_r;
                end
                if (hit_out_s) begin
                    coll_acc_r <= 1'b1;
                end else if (vs_start_out_s) begin
                    coll_acc_r <= 1'b0;
                end
            end
        end
    end

    assign r_o         = acc_s[NUM_LAYERS][3*CW-1:2*CW];
    assign g_o         = acc_s[NUM_LAYERS][2*CW-1:CW];
    assign b_o         = acc_s[NUM_LAYERS][CW-1:0];
    assign valid_o     = v_s[NUM_LAYERS];
    assign hsync_o     = hs_s[NUM_LAYERS];
    assign vsync_o     = vs_s[NUM_LAYERS];
    assign collision_o = collision_r;
    assign frame_o     = frame_r;

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer (NUM_LAYERS=4, CW=4, active-low syncs).
module tb_layer_mixer;

    localparam int NL = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n, pix_ce, valid_i, hsync_i, vsync_i;
    logic [NL*CW-1:0] r_i, g_i, b_i;
    logic [NL-1:0]    a_i;
    logic [2*NL-1:0]  mode_i;
    logic [3*CW-1:0]  bg_i;
    logic [CW-1:0]    r_o, g_o, b_o;
    logic valid_o, hsync_o, vsync_o, collision_o, frame_o;

    int total = 0;
    int bad = 0;
    int frame_cnt = 0;
    bit thr = 1'b0;

    layer_mixer #(.NUM_LAYERS(NL), .CW(CW), .VS_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .valid_i(valid_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .r_i(r_i), .g_i(g_i), .b_i(b_i), .a_i(a_i), .mode_i(mode_i), .bg_i(bg_i),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .valid_o(valid_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .collision_o(collision_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    // frame_o is high for whole clk periods, so one sample per period counts pulse width too.
    always @(negedge clk) begin
        if (rst_n && frame_o) frame_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic ce);
        pix_ce = ce;
        @(posedge clk);
        #1;
    endtask

    // One pixel enable; in throttled mode three idle clocks precede it.
    task automatic en();
        if (thr) repeat (3) tick(1'b0);
        tick(1'b1);
        pix_ce = 1'b0;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
        bg_i = 12'h000; r_i = 16'h0000; g_i = 16'h0000; b_i = 16'h0000; a_i = 4'b0000;
    endtask

    task automatic frame_start(input logic [7:0] m);
        mode_i = m;
        valid_i = 1'b0;
        vsync_i = 1'b0;
        en();
        vsync_i = 1'b1;
        en();
    endtask

    task automatic pix(input string tag, input logic [11:0] bg, input logic [15:0] r,
                       input logic [15:0] g, input logic [15:0] b, input logic [3:0] a,
                       input logic [11:0] exp);
        bg_i = bg; r_i = r; g_i = g; b_i = b; a_i = a;
        valid_i = 1'b1; hsync_i = 1'b0;
        en();
        idle_inputs();
        repeat (4) en();
        chk(tag, {20'h0, r_o, g_o, b_o}, {20'h0, exp});
        chk({tag, "_vld"}, {31'h0, valid_o}, 32'd1);
        chk({tag, "_hs"}, {31'h0, hsync_o}, 32'd0);
        en();
        chk({tag, "_blank"}, {19'h0, valid_o, r_o, g_o, b_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; mode_i = 8'h00;
        idle_inputs();
        repeat (3) tick(1'b0);
        chk("rst_pix", {19'h0, valid_o, r_o, g_o, b_o}, 32'd0);
        chk("rst_sync", {30'h0, hsync_o, vsync_o}, 32'd3);
        chk("rst_colfrm", {30'h0, collision_o, frame_o}, 32'd0);
        rst_n = 1'b1;

        // Latency from reset release, background only.
        valid_i = 1'b1; hsync_i = 1'b0; bg_i = 12'h5A3;
        for (int e = 1; e <= 5; e++) begin
            en();
            if (e < 5) chk("lat_pre", {31'h0, valid_o}, 32'd0);
        end
        chk("lat_rgb", {20'h0, r_o, g_o, b_o}, 32'h5A3);
        chk("lat_vld", {31'h0, valid_o}, 32'd1);
        chk("lat_hs", {31'h0, hsync_o}, 32'd0);

        // Reset in the middle of a run of valid pixels.
        repeat (2) en();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_pix", {19'h0, valid_o, r_o, g_o, b_o}, 32'd0);
        chk("mrst_sync", {30'h0, hsync_o, vsync_o}, 32'd3);
        tick(1'b1);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            en();
            if (e < 5) chk("mrst_pre", {31'h0, valid_o}, 32'd0);
        end
        chk("mrst_rgb", {20'h0, r_o, g_o, b_o}, 32'h5A3);
        chk("mrst_vld", {31'h0, valid_o}, 32'd1);
        idle_inputs();
        repeat (5) en();

        // Frame 1: L1 and L3 over; L1+L3 opaque at one pixel is a collision.
        frame_start(8'h44);
        pix("over_top", 12'h000, 16'h00F0, 16'h0000, 16'hF000, 4'b1010, 12'h00F);
        pix("over_a0", 12'h000, 16'h00F0, 16'h0000, 16'hF000, 4'b0010, 12'hF00);
        chk("col_f1", {31'h0, collision_o}, 32'd0);

        // Frame 2, throttled to one enable in four: L2 add.
        thr = 1'b1;
        frame_start(8'h20);
        pix("add_sat", 12'h800, 16'h0A00, 16'h0000, 16'h0000, 4'b0100, 12'hF00);
        pix("add_700", 12'h300, 16'h0400, 16'h0000, 16'h0000, 4'b0100, 12'h700);
        pix("add_a0", 12'h300, 16'h0400, 16'h0000, 16'h0000, 4'b0000, 12'h300);
        pix("add_gb", 12'h0F1, 16'h0000, 16'h0300, 16'h0E00, 4'b0100, 12'h0FF);
        chk("col_f2", {31'h0, collision_o}, 32'd1);
        thr = 1'b0;

        // Frame 3: L1 and L2 over collide; mode change mid-frame must not apply yet.
        frame_start(8'h14);
        pix("coll_px", 12'h00A, 16'h00F0, 16'h0F00, 16'h0000, 4'b0110, 12'h0F0);
        chk("col_f3", {31'h0, collision_o}, 32'd0);
        mode_i = 8'h00;
        pix("tear_old", 12'h00A, 16'h00F0, 16'h0F00, 16'h0000, 4'b0110, 12'h0F0);

        // Frame 4: the all-off modes now apply.
        frame_start(8'h00);
        pix("tear_new", 12'h00A, 16'h00F0, 16'h0F00, 16'h0000, 4'b0110, 12'h00A);
        chk("col_f4", {31'h0, collision_o}, 32'd1);

        // Frame 5: no hits in frame 4.
        frame_start(8'h00);
        repeat (6) en();
        chk("col_f5", {31'h0, collision_o}, 32'd0);
        repeat (2) en();
        chk("frames", frame_cnt, 32'd5);
        chk("vs_idle", {31'h0, vsync_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
